// File: rtl/arb_pkg.sv
// Shared types and widths for mem_arbiter.
`include "defs_params_common.svh"

package arb_pkg;

  localparam int unsigned ARB_PERF_W = 32;
  localparam int unsigned ARB_AW_DEF = `ARB_AW_DEFAULT;
  localparam int unsigned ARB_DW_DEF = `ARB_DW_DEFAULT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    DONE_IF = 3'd3,
    DONE_DM = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_perf_cnt.sv
// Free-running wrapping event counter used by the arbiter performance monitors.
module arb_perf_cnt
  import arb_pkg::*;
#(
  parameter int unsigned W = ARB_PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles; natural wrap at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/defs_params_common.svh
// Shared default widths for the memory arbiter slice.
`ifndef DEFS_PARAMS_COMMON_SVH
`define DEFS_PARAMS_COMMON_SVH

`define ARB_AW_DEFAULT 32
`define ARB_DW_DEFAULT 32

`endif

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported variable-latency unified memory.
// Data requests win over fetches; a redirect discards an in-flight fetch.
// Optional performance counters are enabled with the ARB_PERF_EN macro.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW = ARB_AW_DEF,
  parameter int unsigned DW = ARB_DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wd,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
`ifdef ARB_PERF_EN
  ,
  output logic [ARB_PERF_W-1:0] perf_conflict,
  output logic [ARB_PERF_W-1:0] perf_busy
`endif
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       grant_dm;
  logic       grant_if;
  logic       discard_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant decode; grants only ever issue from IDLE.
  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end else if (if_req && !if_flush) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF: if (mem_ack) state_d = DONE_IF;
      BUSY_DM: if (mem_ack) state_d = DONE_DM;
      DONE_IF: state_d = IDLE;
      DONE_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request registers, loaded on grant and held through the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else if (grant_dm) begin
      mem_we   <= dm_we;
      mem_addr <= dm_addr;
      mem_wd   <= dm_wd;
    end else if (grant_if) begin
      mem_we   <= 1'b0;
      mem_addr <= if_addr;
    end
  end

  // Read-data capture; acks outside BUSY states are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (state_q == BUSY_IF && mem_ack) if_rdata <= mem_rdata;
      if (state_q == BUSY_DM && mem_ack) dm_rdata <= mem_rdata;
    end
  end

  // Discard flag: a redirect during a fetch kills its completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_q <= 1'b0;
    end else if (state_q == BUSY_IF && if_flush) begin
      discard_q <= 1'b1;
    end else if (state_d == IDLE) begin
      discard_q <= 1'b0;
    end
  end

  assign mem_req  = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign dm_valid = (state_q == DONE_DM);
  assign if_valid = (state_q == DONE_IF) && !discard_q && !if_flush;

`ifdef ARB_PERF_EN
  logic conflict_inc;
  assign conflict_inc = (state_q == IDLE) && if_req && dm_req;

  arb_perf_cnt #(.W(ARB_PERF_W)) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict_inc),
    .count (perf_conflict)
  );

  arb_perf_cnt #(.W(ARB_PERF_W)) u_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_req),
    .count (perf_busy)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_conflict;
  logic [31:0]   perf_busy;
`endif

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef ARB_PERF_EN
    ,
    .perf_conflict (perf_conflict),
    .perf_busy     (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  bit          auto_mem = 1'b0;
  int          lat_cfg = 0;
  int          wait_cnt = 0;
  logic [31:0] resp_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  logic [31:0] seen_addr [$];
  logic        seen_we   [$];
  logic [31:0] seen_wd   [$];
  logic [31:0] exp_busy = 32'd0;
  logic [31:0] exp_conf = 32'd0;

  function automatic int ix(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then play the memory: ack after lat_cfg extra cycles of mem_req.
  task automatic step();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (auto_mem && mem_req === 1'b1) begin
      if (wait_cnt >= lat_cfg) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        seen_addr.push_back(mem_addr);
        seen_we.push_back(mem_we);
        seen_wd.push_back(mem_wd);
        if (mem_we) begin
          resp_mem[ix(mem_addr)] = mem_wd;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = resp_mem[ix(mem_addr)];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  // One scenario: optional data request and/or fetch presented together in an
  // IDLE cycle. fmode: 0 no flush, 1 flush while the fetch is in memory,
  // 2 flush in the fetch completion cycle.
  task automatic run_txn(input bit do_dm, input bit we, input logic [31:0] daddr,
                         input logic [31:0] wd, input bit do_if, input logic [31:0] iaddr,
                         input int lat, input int fmode);
    int t_dm, s_if, t_if, f_cyc, last, c_dm, c_if, n_dm, n_if, k;
    bit fl, flushed;
    logic [31:0] exp_dm, exp_if, got_dmd, got_ifd;
    lat_cfg = lat;
    seen_addr.delete(); seen_we.delete(); seen_wd.delete();
    t_dm  = do_dm ? 2 + lat : -1;
    s_if  = do_dm ? t_dm + 1 : 0;
    t_if  = s_if + 2 + lat;
    fl    = do_if && (fmode != 0);
    f_cyc = (fmode == 1) ? s_if + 1 + int'($urandom_range(0, lat)) : t_if;
    exp_dm = 32'd0;
    exp_if = 32'd0;
    if (do_dm) begin
      if (we) ref_mem[ix(daddr)] = wd;
      else    exp_dm = ref_mem[ix(daddr)];
    end
    if (do_if) exp_if = ref_mem[ix(iaddr)];
    exp_busy = exp_busy + 32'((int'(do_dm) + int'(do_if)) * (lat + 1));
    if (do_dm && do_if) exp_conf = exp_conf + 32'd1;
    last = (do_if ? t_if : t_dm) + 2;
    c_dm = -1; c_if = -1; n_dm = 0; n_if = 0; got_dmd = 0; got_ifd = 0;
    for (int c = 0; c <= last; c++) begin
      step();
      flushed  = fl && (c >= f_cyc);
      dm_req   = do_dm && (n_dm == 0);
      dm_we    = we;
      dm_addr  = daddr;
      dm_wd    = wd;
      if_req   = do_if && (n_if == 0) && !flushed;
      if_addr  = iaddr;
      if_flush = fl && (c == f_cyc);
      #1;
      if (dm_valid === 1'b1) begin
        if (c_dm < 0) begin c_dm = c; got_dmd = dm_rdata; end
        n_dm++;
        check("dm_done_no_mem_req", 32'(mem_req), 32'd0);
      end
      if (if_valid === 1'b1) begin
        if (c_if < 0) begin c_if = c; got_ifd = if_rdata; end
        n_if++;
        check("if_done_no_mem_req", 32'(mem_req), 32'd0);
      end
    end
    dm_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
    if (do_dm) begin
      check("dm_valid_cycle", 32'(c_dm), 32'(t_dm));
      check("dm_valid_count", 32'(n_dm), 32'd1);
      if (!we) check("dm_rdata", got_dmd, exp_dm);
    end
    if (do_if && !fl) begin
      check("if_valid_cycle", 32'(c_if), 32'(t_if));
      check("if_valid_count", 32'(n_if), 32'd1);
      check("if_rdata", got_ifd, exp_if);
    end
    if (fl) check("if_flushed_count", 32'(n_if), 32'd0);
    check("mem_txn_count", 32'(seen_addr.size()), 32'(int'(do_dm) + int'(do_if)));
    k = 0;
    if (do_dm && seen_addr.size() > k) begin
      check("dm_mem_addr", seen_addr[k], daddr);
      check("dm_mem_we", 32'(seen_we[k]), 32'(we));
      if (we) check("dm_mem_wd", seen_wd[k], wd);
      k++;
    end
    if (do_if && seen_addr.size() > k) begin
      check("if_mem_addr", seen_addr[k], iaddr);
      check("if_mem_we", 32'(seen_we[k]), 32'd0);
    end
  endtask

  initial begin
    int nv, v0, v1, fm;
    bit rd, ri;
    logic [31:0] v;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wd = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      resp_mem[i] = v;
      ref_mem[i]  = v;
    end
    resp_mem[64] = 32'hDEAD_BEEF;
    ref_mem[64]  = 32'hDEAD_BEEF;

    // Reset values.
    step(); step(); #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_dm_valid", 32'(dm_valid), 32'd0);
    step(); reset = 1'b0; #1;
    auto_mem = 1'b1;
    step(); #1;

    // Zero-wait load.
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 0, 0);
    // Simultaneous store and fetch, latency 3.
    run_txn(1'b1, 1'b1, 32'h200, 32'h1234, 1'b1, 32'h40, 3, 0);

    // Flush coincident with a fetch request in IDLE blocks the grant.
    step(); if_req = 1'b1; if_addr = 32'h80; if_flush = 1'b1; #1;
    step(); if_req = 1'b0; if_flush = 1'b0; #1;
    check("flush_idle_no_grant", 32'(mem_req), 32'd0);

    // Fetch flushed while in memory, then a normal fetch.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 2, 1);
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h90, 1, 0);
    // Flush in the fetch completion cycle.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA0, 0, 2);

    // Reset during a data transaction, stale ack afterwards.
    auto_mem = 1'b0;
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; #1;
    step(); #1;
    check("rstmid_busy", 32'(mem_req), 32'd1);
    step(); reset = 1'b1; #1;
    step(); reset = 1'b0; dm_req = 1'b0; #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_dm_valid", 32'(dm_valid), 32'd0);
    step(); #1;
    step(); mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("stale_ack_dm_valid", 32'(dm_valid), 32'd0);
      check("stale_ack_mem_req", 32'(mem_req), 32'd0);
    end
    check("stale_ack_dm_rdata", dm_rdata, 32'd0);
    exp_busy = 32'd0;
    exp_conf = 32'd0;
    auto_mem = 1'b1;

    // Back-to-back fetches with the request held and the address advancing.
    lat_cfg = 1;
    seen_addr.delete(); seen_we.delete(); seen_wd.delete();
    nv = 0; v0 = -1; v1 = -1;
    for (int c = 0; c <= 9; c++) begin
      step();
      if_req  = (nv < 2);
      if_addr = (nv == 0) ? 32'h0 : 32'h4;
      #1;
      if (if_valid === 1'b1) begin
        check("b2b_if_rdata", if_rdata, ref_mem[ix(if_addr)]);
        check("b2b_no_mem_req", 32'(mem_req), 32'd0);
        if (nv == 0) v0 = c; else v1 = c;
        nv++;
      end
    end
    if_req = 1'b0;
    exp_busy = exp_busy + 32'd4;
    check("b2b_first_cycle", 32'(v0), 32'd3);
    check("b2b_second_cycle", 32'(v1), 32'd7);
    check("b2b_valid_count", 32'(nv), 32'd2);
    check("b2b_txn_count", 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() == 2) begin
      check("b2b_addr0", seen_addr[0], 32'h0);
      check("b2b_addr1", seen_addr[1], 32'h4);
    end
    step(); #1;

    // Randomized mixes of loads, stores, fetches, latencies and flushes.
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom);
      ri = rd ? 1'($urandom) : 1'b1;
      fm = int'($urandom_range(0, 3));
      if (fm == 3) fm = 0;
      run_txn(rd, 1'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom,
              ri, {24'h0, 6'($urandom), 2'b00}, int'($urandom_range(0, 3)), fm);
    end

`ifdef ARB_PERF_EN
    check("perf_conflict", perf_conflict, exp_conf);
    check("perf_busy", perf_busy, exp_busy);
    step();
    force dut.u_busy_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_busy_cnt.count;
    exp_busy = 32'hFFFF_FFFF;
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 0, 0);
    check("perf_busy_wrap", perf_busy, exp_busy);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-ported, variable-latency unified memory between two requesters of the 5-stage RV32I pipeline: the instruction-fetch port (IF) and the data-memory port (MEM).
- Grants one requester at a time and drives the memory-side req/ack handshake.
- Returns read data and a one-cycle completion pulse per requester; the hazard unit turns these into stallF/stallM.
- Data requests beat fetch requests; an in-flight fetch can be discarded on a redirect.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_valid or if_flush
- if_addr  in  AW  fetch address; stable while if_req
- if_flush  in  1  redirect (taken branch/jump in D); kills the current fetch
- if_rdata  out  DW  fetched instruction; valid only with if_valid
- if_valid  out  1  one-cycle fetch-completion pulse
- dm_req  in  1  data request (load or store in M); level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load; stable while dm_req
- dm_addr  in  AW  data address; stable while dm_req
- dm_wd  in  DW  store data; stable while dm_req
- dm_rdata  out  DW  load data; valid only with dm_valid
- dm_valid  out  1  one-cycle data-completion pulse; loads and stores
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

## Operation
States: IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM.

IDLE:
- dm_req=1 → latch dm_we/dm_addr/dm_wd into mem_* registers; go to BUSY_DM.
- Else if_req=1 and if_flush=0 → latch if_addr (mem_we=0); go to BUSY_IF.
- Else stay in IDLE.

BUSY_x:
- mem_req=1; mem_* registers held stable.
- On mem_ack: capture mem_rdata into the x rdata register; go to DONE_x.

DONE_x:
- x_valid=1 for exactly this cycle; return to IDLE.
- No grant is issued in DONE, so a level request still high from the finished transaction is never re-granted.

Flush and priority:
- if_flush in BUSY_IF sets a discard flag. The memory transaction still completes; DONE_IF then suppresses if_valid.
- if_flush in DONE_IF gates if_valid low.
- if_flush in IDLE blocks the fetch grant that cycle.
- The discard flag clears on entry to IDLE.
- Fixed priority, data first. Fetch cannot starve: a pending dm_req holds the pipeline, so no new data request arrives until the fetch is serviced.

Boundary rules:
- mem_ack in IDLE or DONE is ignored.
- mem_ack is never expected while mem_req=0.
- Data is returned unchanged in all cases; no width or arithmetic conversion.

## Timing
- Reset: state=IDLE; mem_req, mem_we, if_valid, dm_valid=0; mem_addr, mem_wd, if_rdata, dm_rdata=0; discard=0.
- Reset mid-transaction abandons it. A later mem_ack from that transaction arrives in IDLE and is ignored.
- All outputs are registered or decoded from state; there is no combinational path from mem_ack to x_valid.
- Request latched in IDLE at cycle 0:
  - mem_req rises at cycle 1.
  - mem_ack is earliest at cycle 1; call its cycle k.
  - x_valid at cycle k+1.
  - IDLE at cycle k+2.
  - Minimum request-to-valid: 2 cycles; minimum occupancy per transaction: 3 cycles.
- Simultaneous if_req and dm_req in IDLE → DM is granted; IF waits at least 3 cycles.
- Simultaneous if_flush and if_req in IDLE → no grant that cycle.

## Configuration
- ARB_PERF_EN defined:
  - Adds outputs perf_conflict (32) and perf_busy (32).
  - perf_conflict increments each IDLE cycle where both if_req and dm_req are high.
  - perf_busy increments each cycle mem_req=1.
  - Both wrap from 0xFFFF_FFFF to 0 and reset to 0.
- ARB_PERF_EN undefined: these ports and their counters do not exist. Arbiter behaviour is identical either way.

## Structure
- Package arb_pkg holds arb_state_t (the five-state enum) and ARB_PERF_W = 32.
- Include defs_params_common.svh.
- Sub-module arb_perf_cnt: a single wrapping counter with clk, reset and inc ports. It is instantiated twice, only under ARB_PERF_EN.

## Test plan
- Load, zero wait: dm_req=1, dm_we=0, dm_addr=0x100; mem_ack in the first cycle of mem_req with mem_rdata=0xDEADBEEF → mem_addr=0x100, dm_valid pulses 2 cycles after the request, dm_rdata=0xDEADBEEF.
- Conflict: if_req (0x40) and dm_req store (0x200, 0x1234) in the same cycle; memory latency 3 → store issued first with mem_we=1 and mem_wd=0x1234, dm_valid; then fetch of 0x40, if_valid. With ARB_PERF_EN, perf_conflict=1.
- Flush: fetch 0x80 granted; if_flush in BUSY_IF; mem_ack after 2 cycles → if_valid never asserts, state returns to IDLE, next if_req 0x90 is granted normally.
- Reset mid-op: reset during BUSY_DM → next cycle mem_req=0, dm_valid=0; a stale mem_ack 2 cycles later produces no valid pulse.
- Back-to-back fetches: if_req held through if_valid with address updated 0x0 → 0x4 → exactly one if_valid per address, and mem_req is never asserted during DONE_IF.
- Counter wrap (ARB_PERF_EN): force perf_busy to 0xFFFF_FFFF; one mem_req cycle → 0x0000_0000.
